// File: rtl/track_ctrl_if.sv
// Signal bundle between the box/template tracker sequencer and its surroundings.
//  master : frame timing, buttons, manual centre counters, correlator results in;
//           box centre, template centre, capture strobe and status out
//  slave  : the sequencer side (track_ctrl)
interface track_ctrl_if;
   logic        frame_start;
   logic        btn_capture;
   logic        btn_track;
   logic [9:0]  manual_x;
   logic [9:0]  manual_y;
   logic        max_ready;
   logic [9:0]  max_x;
   logic [9:0]  max_y;
   logic [15:0] max_score;
   logic [9:0]  c_x;
   logic [9:0]  c_y;
   logic [9:0]  cap_x;
   logic [9:0]  cap_y;
   logic        template_capture;
   logic        tracking_mode;
   logic        lost;
   logic [2:0]  state;

   modport master (
      output frame_start, btn_capture, btn_track, manual_x, manual_y,
             max_ready, max_x, max_y, max_score,
      input  c_x, c_y, cap_x, cap_y, template_capture, tracking_mode, lost, state
   );

   modport slave (
      input  frame_start, btn_capture, btn_track, manual_x, manual_y,
             max_ready, max_x, max_y, max_score,
      output c_x, c_y, cap_x, cap_y, template_capture, tracking_mode, lost, state
   );
endinterface

// File: rtl/track_ctrl.sv
// Sequencing FSM for the box/template tracker.
// Debounces the capture/track buttons, arms a one-frame template capture at the
// manual box centre, then tracks by gating correlator maxima into the box centre
// and declares LOST after LOST_FRAMES consecutive missed frames.
//
// Ports:
//  clk, rst_n (synchronous, active-low)
//  bus (track_ctrl_if.slave):
//   in : frame_start, btn_capture, btn_track, manual_x/y, max_ready, max_x/y, max_score
//   out: c_x/y (box centre), cap_x/y (template centre), template_capture,
//        tracking_mode, lost, state
//
// Build option: TRACK_SMOOTH_EN -- good TRACK updates move the centre halfway
// towards the match, c <= (c + max) >> 1, instead of jumping to it.
//
// state      | meaning
// MANUAL  0  | centre follows manual counters
// ARM     1  | template centre latched, waiting for frame start
// CAPTURE 2  | template memory written for one whole frame
// TRACK   3  | centre follows good correlator matches
// LOST    4  | too many missed frames, waiting for any strong match
module track_ctrl #(
   parameter logic [19:0] DEB_CYCLES  = 20'd1_000_000,
   parameter logic [15:0] SCORE_MIN   = 16'd1000,
   parameter logic [9:0]  MAX_STEP    = 10'd64,
   parameter logic [3:0]  LOST_FRAMES = 4'd8
) (
   input  logic         clk,
   input  logic         rst_n,
   track_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_MANUAL  = 3'd0,
      ST_ARM     = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_TRACK   = 3'd3,
      ST_LOST    = 3'd4
   } state_t;

   // One extra count past the fire point so a held button never re-fires.
   localparam logic [20:0] DEB_FIRE  = {1'b0, DEB_CYCLES};
   localparam logic [20:0] DEB_LIMIT = DEB_FIRE + 21'd1;

   logic [20:0] deb_cap_cnt;
   logic [20:0] deb_trk_cnt;
   logic        press_cap;
   logic        press_trk;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         deb_cap_cnt <= '0;
         deb_trk_cnt <= '0;
         press_cap   <= 1'b0;
         press_trk   <= 1'b0;
      end else begin
         if (!bus.btn_capture)
            deb_cap_cnt <= '0;
         else if (deb_cap_cnt != DEB_LIMIT)
            deb_cap_cnt <= deb_cap_cnt + 21'd1;
         if (!bus.btn_track)
            deb_trk_cnt <= '0;
         else if (deb_trk_cnt != DEB_LIMIT)
            deb_trk_cnt <= deb_trk_cnt + 21'd1;
         press_cap <= bus.btn_capture && (deb_cap_cnt == DEB_FIRE);
         press_trk <= bus.btn_track   && (deb_trk_cnt == DEB_FIRE);
      end
   end

   state_t      state_q;
   logic [9:0]  c_x_q, c_y_q, cap_x_q, cap_y_q;
   logic        tcap_q, trk_mode_q, lost_q;
   logic [3:0]  miss_cnt;
   logic        frame_hit;   // a max_ready arrived in the current frame
   logic        frame_bad;   // a rejected match arrived in the current frame

   // Absolute per-axis jump in 11 bits so no 10-bit wrap can fake a small step.
   logic [10:0] dx, dy, adx, ady;
   logic        score_ok, good;
   logic [9:0]  upd_x, upd_y;
   logic        frame_missed;
   logic [3:0]  miss_base, miss_next;

   always_comb begin
      dx       = {1'b0, bus.max_x} - {1'b0, c_x_q};
      dy       = {1'b0, bus.max_y} - {1'b0, c_y_q};
      adx      = dx[10] ? (~dx + 11'd1) : dx;
      ady      = dy[10] ? (~dy + 11'd1) : dy;
      score_ok = (bus.max_score >= SCORE_MIN);
      good     = score_ok && (adx <= {1'b0, MAX_STEP}) && (ady <= {1'b0, MAX_STEP});
   end

`ifdef TRACK_SMOOTH_EN
   logic [10:0] sum_x, sum_y;
   always_comb begin
      sum_x = {1'b0, c_x_q} + {1'b0, bus.max_x};
      sum_y = {1'b0, c_y_q} + {1'b0, bus.max_y};
      upd_x = sum_x[10:1];
      upd_y = sum_y[10:1];
   end
`else
   always_comb begin
      upd_x = bus.max_x;
      upd_y = bus.max_y;
   end
`endif

   // A max_ready coincident with frame_start belongs to the frame that is ending.
   always_comb begin
      frame_missed = !(frame_hit || bus.max_ready) || frame_bad || (bus.max_ready && !good);
      miss_base    = (bus.max_ready && good) ? 4'd0 : miss_cnt;
      if (!frame_missed)
         miss_next = miss_base;
      else if (miss_base >= LOST_FRAMES)
         miss_next = LOST_FRAMES;
      else
         miss_next = miss_base + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_MANUAL;
         c_x_q      <= 10'd320;
         c_y_q      <= 10'd240;
         cap_x_q    <= '0;
         cap_y_q    <= '0;
         tcap_q     <= 1'b0;
         trk_mode_q <= 1'b0;
         lost_q     <= 1'b0;
         miss_cnt   <= '0;
         frame_hit  <= 1'b0;
         frame_bad  <= 1'b0;
      end else begin
         case (state_q)
            ST_MANUAL: begin
               c_x_q <= bus.manual_x;
               c_y_q <= bus.manual_y;
               if (press_cap && !press_trk) begin
                  cap_x_q <= bus.manual_x;
                  cap_y_q <= bus.manual_y;
                  state_q <= ST_ARM;
               end
            end
            ST_ARM: begin
               if (press_trk) begin
                  state_q <= ST_MANUAL;
               end else if (bus.frame_start) begin
                  state_q <= ST_CAPTURE;
                  tcap_q  <= 1'b1;
               end
            end
            ST_CAPTURE: begin
               if (press_trk) begin
                  state_q <= ST_MANUAL;
                  tcap_q  <= 1'b0;
               end else if (bus.frame_start) begin
                  state_q    <= ST_TRACK;
                  tcap_q     <= 1'b0;
                  trk_mode_q <= 1'b1;
                  miss_cnt   <= '0;
                  frame_hit  <= 1'b0;
                  frame_bad  <= 1'b0;
               end
            end
            ST_TRACK, ST_LOST: begin
               if (press_trk) begin
                  state_q    <= ST_MANUAL;
                  trk_mode_q <= 1'b0;
                  lost_q     <= 1'b0;
               end else if (press_cap) begin
                  cap_x_q    <= c_x_q;
                  cap_y_q    <= c_y_q;
                  state_q    <= ST_ARM;
                  trk_mode_q <= 1'b0;
                  lost_q     <= 1'b0;
               end else if (state_q == ST_LOST) begin
                  if (bus.max_ready && score_ok) begin
                     c_x_q     <= bus.max_x;
                     c_y_q     <= bus.max_y;
                     miss_cnt  <= '0;
                     state_q   <= ST_TRACK;
                     lost_q    <= 1'b0;
                     frame_hit <= !bus.frame_start;
                     frame_bad <= 1'b0;
                  end
               end else begin
                  if (bus.max_ready && good) begin
                     c_x_q    <= upd_x;
                     c_y_q    <= upd_y;
                     miss_cnt <= '0;
                  end
                  if (bus.frame_start) begin
                     frame_hit <= 1'b0;
                     frame_bad <= 1'b0;
                     miss_cnt  <= miss_next;
                     if (miss_next == LOST_FRAMES) begin
                        state_q <= ST_LOST;
                        lost_q  <= 1'b1;
                     end
                  end else if (bus.max_ready) begin
                     frame_hit <= 1'b1;
                     if (!good)
                        frame_bad <= 1'b1;
                  end
               end
            end
            default: begin
               state_q    <= ST_MANUAL;
               tcap_q     <= 1'b0;
               trk_mode_q <= 1'b0;
               lost_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.c_x              = c_x_q;
   assign bus.c_y              = c_y_q;
   assign bus.cap_x            = cap_x_q;
   assign bus.cap_y            = cap_y_q;
   assign bus.template_capture = tcap_q;
   assign bus.tracking_mode    = trk_mode_q;
   assign bus.lost             = lost_q;
   assign bus.state            = state_q;

endmodule

// File: tb/tb_track_ctrl.sv
// Bench for track_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_track_ctrl;
   localparam int DEB   = 4;
   localparam int SMIN  = 1000;
   localparam int STEP  = 64;
   localparam int LOSTN = 8;
   localparam int MAN = 0, ARM = 1, CAP = 2, TRK = 3, LST = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   track_ctrl_if bus();

   track_ctrl #(.DEB_CYCLES(20'd4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int errs  = 0;
   bit chk_en = 1'b0;

   // Behavioural model state.
   int m_st, m_cx, m_cy, m_capx, m_capy, m_miss;
   bit m_had, m_bad;
   int run_c, run_t;
   bit pr_c, pr_t;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   always @(posedge clk) begin : model
      bit pc, pt, mr, fs, good;
      int mx, my, ms;
      if (!rst_n) begin
         m_st = MAN; m_cx = 320; m_cy = 240; m_capx = 0; m_capy = 0;
         m_miss = 0; m_had = 0; m_bad = 0;
         run_c = 0; run_t = 0; pr_c = 0; pr_t = 0;
      end else begin
         pc = pr_c; pt = pr_t;
         run_c = bus.btn_capture ? ((run_c < 1000) ? run_c + 1 : run_c) : 0;
         run_t = bus.btn_track   ? ((run_t < 1000) ? run_t + 1 : run_t) : 0;
         pr_c = (run_c == DEB + 1);
         pr_t = (run_t == DEB + 1);
         mr = bus.max_ready; fs = bus.frame_start;
         mx = int'(bus.max_x); my = int'(bus.max_y); ms = int'(bus.max_score);
         case (m_st)
            MAN: begin
               if (pc && !pt) begin
                  m_capx = int'(bus.manual_x); m_capy = int'(bus.manual_y); m_st = ARM;
               end
               m_cx = int'(bus.manual_x); m_cy = int'(bus.manual_y);
            end
            ARM: if (pt) m_st = MAN; else if (fs) m_st = CAP;
            CAP: begin
               if (pt) m_st = MAN;
               else if (fs) begin m_st = TRK; m_miss = 0; m_had = 0; m_bad = 0; end
            end
            default: begin
               if (pt) m_st = MAN;
               else if (pc) begin m_capx = m_cx; m_capy = m_cy; m_st = ARM; end
               else if (m_st == LST) begin
                  if (mr && ms >= SMIN) begin
                     m_cx = mx; m_cy = my; m_miss = 0; m_st = TRK;
                     m_had = !fs; m_bad = 0;
                  end
               end else begin
                  if (mr) begin
                     good = (ms >= SMIN) && (iabs(mx - m_cx) <= STEP) && (iabs(my - m_cy) <= STEP);
                     m_had = 1;
                     if (good) begin
`ifdef TRACK_SMOOTH_EN
                        m_cx = (m_cx + mx) / 2; m_cy = (m_cy + my) / 2;
`else
                        m_cx = mx; m_cy = my;
`endif
                        m_miss = 0;
                     end else m_bad = 1;
                  end
                  if (fs) begin
                     if (!m_had || m_bad) m_miss = (m_miss + 1 > LOSTN) ? LOSTN : m_miss + 1;
                     m_had = 0; m_bad = 0;
                     if (m_miss == LOSTN) m_st = LST;
                  end
               end
            end
         endcase
      end
   end

   task automatic cmp(input string nm, input int act, input int exp);
      if (act != exp) begin
         errs++;
         $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         n_vec++;
         cmp("state", int'(bus.state), m_st);
         cmp("c_x", int'(bus.c_x), m_cx);
         cmp("c_y", int'(bus.c_y), m_cy);
         cmp("cap_x", int'(bus.cap_x), m_capx);
         cmp("cap_y", int'(bus.cap_y), m_capy);
         cmp("template_capture", int'(bus.template_capture), int'(m_st == CAP));
         cmp("tracking_mode", int'(bus.tracking_mode), int'(m_st == TRK || m_st == LST));
         cmp("lost", int'(bus.lost), int'(m_st == LST));
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      cmp(nm, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_fs();
      bus.frame_start = 1'b1; step(1); bus.frame_start = 1'b0;
   endtask

   task automatic pulse_mr(input int x, input int y, input int s, input bit with_fs);
      bus.max_x = 10'(x); bus.max_y = 10'(y); bus.max_score = 16'(s);
      bus.max_ready = 1'b1; bus.frame_start = with_fs;
      step(1);
      bus.max_ready = 1'b0; bus.frame_start = 1'b0;
   endtask

   function automatic int clamp10(input int v);
      return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
   endfunction

   int cx0, cy0, hc, ht;

   initial begin
      bus.frame_start = 0; bus.btn_capture = 0; bus.btn_track = 0;
      bus.manual_x = 10'd100; bus.manual_y = 10'd50;
      bus.max_ready = 0; bus.max_x = 0; bus.max_y = 0; bus.max_score = 0;
      @(posedge clk); #1 chk_en = 1'b1;
      step(2);
      chk("rst_state", int'(bus.state), 0);
      chk("rst_c_x", int'(bus.c_x), 320);
      chk("rst_c_y", int'(bus.c_y), 240);
      chk("rst_cap_x", int'(bus.cap_x), 0);
      chk("rst_tcap", int'(bus.template_capture), 0);
      rst_n = 1'b1;
      step(2);

      // 1: capture press, arm, one-frame capture
      bus.btn_capture = 1'b1; step(6); bus.btn_capture = 1'b0; step(2);
      chk("t1_arm", int'(bus.state), 1);
      chk("t1_cap_x", int'(bus.cap_x), 100);
      chk("t1_cap_y", int'(bus.cap_y), 50);
      pulse_fs();
      chk("t1_capture", int'(bus.state), 2);
      chk("t1_tcap", int'(bus.template_capture), 1);
      step(10);
      pulse_fs();
      chk("t1_track", int'(bus.state), 3);
      chk("t1_tcap_drop", int'(bus.template_capture), 0);

      // 2: good match
      step(3);
      pulse_mr(130, 60, 2000, 1'b0);
`ifdef TRACK_SMOOTH_EN
      cx0 = 115; cy0 = 55;
`else
      cx0 = 130; cy0 = 60;
`endif
      chk("t2_c_x", int'(bus.c_x), cx0);
      chk("t2_c_y", int'(bus.c_y), cy0);
      step(3); pulse_fs();

      // 3: oversized jumps for 8 frames
      repeat (7) begin step(3); pulse_mr(300, 60, 5000, 1'b0); step(3); pulse_fs(); end
      chk("t3_still_track", int'(bus.state), 3);
      chk("t3_hold_x", int'(bus.c_x), cx0);
      step(3); pulse_mr(300, 60, 5000, 1'b0); step(3); pulse_fs();
      chk("t3_lost_state", int'(bus.state), 4);
      chk("t3_lost", int'(bus.lost), 1);

      // 4: re-acquire threshold
      step(2); pulse_mr(300, 60, 999, 1'b0);
      chk("t4_999_lost", int'(bus.state), 4);
      step(2); pulse_mr(300, 60, 1000, 1'b0);
      chk("t4_reacq", int'(bus.state), 3);
      chk("t4_c_x", int'(bus.c_x), 300);
      chk("t4_lost0", int'(bus.lost), 0);

      // 5: empty frames, then coincident good match credited to the ending frame
      step(2); pulse_fs();
      repeat (8) begin step(3); pulse_fs(); end
      chk("t5_lost", int'(bus.state), 4);
      pulse_mr(300, 60, 1500, 1'b0);
      step(2); pulse_fs();
      step(3); pulse_mr(300, 60, 2000, 1'b1);
      repeat (7) begin step(3); pulse_fs(); end
      chk("t5_coincident", int'(bus.state), 3);
      step(3); pulse_fs();
      chk("t5_lost_again", int'(bus.state), 4);

      // 6: both buttons, then reset during capture
      pulse_mr(300, 60, 2000, 1'b0);
      bus.btn_capture = 1'b1; bus.btn_track = 1'b1; step(6);
      bus.btn_capture = 1'b0; bus.btn_track = 1'b0; step(1);
      chk("t6_both_manual", int'(bus.state), 0);
      bus.manual_x = 10'd200; bus.manual_y = 10'd100;
      bus.btn_capture = 1'b1; step(6); bus.btn_capture = 1'b0; step(1);
      pulse_fs(); step(3);
      chk("t6_in_capture", int'(bus.state), 2);
      rst_n = 1'b0; step(1);
      chk("t6_rst_state", int'(bus.state), 0);
      chk("t6_rst_tcap", int'(bus.template_capture), 0);
      chk("t6_rst_c_x", int'(bus.c_x), 320);
      chk("t6_rst_c_y", int'(bus.c_y), 240);
      rst_n = 1'b1;

      // randomized phase
      hc = 0; ht = 0;
      for (int i = 0; i < 5000; i++) begin
         bus.frame_start = ($urandom_range(0, 11) == 0);
         bus.max_ready   = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) != 0) begin
            bus.max_x = 10'(clamp10(m_cx + int'($urandom_range(0, 160)) - 80));
            bus.max_y = 10'(clamp10(m_cy + int'($urandom_range(0, 160)) - 80));
         end else begin
            bus.max_x = 10'($urandom_range(0, 1023));
            bus.max_y = 10'($urandom_range(0, 1023));
         end
         bus.max_score = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 999))
                                                     : 16'($urandom_range(990, 3000));
         if (hc == 0 && $urandom_range(0, 59) == 0) hc = $urandom_range(2, 9);
         if (ht == 0 && $urandom_range(0, 199) == 0) ht = $urandom_range(2, 9);
         bus.btn_capture = (hc > 0); if (hc > 0) hc--;
         bus.btn_track   = (ht > 0); if (ht > 0) ht--;
         if ($urandom_range(0, 19) == 0) begin
            bus.manual_x = 10'($urandom_range(0, 1023));
            bus.manual_y = 10'($urandom_range(0, 1023));
         end
         rst_n = ($urandom_range(0, 799) != 0);
         step(1);
      end
      rst_n = 1'b1; bus.frame_start = 0; bus.max_ready = 0;
      bus.btn_capture = 0; bus.btn_track = 0;
      step(3);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
      $finish;
   end
endmodule
